// File: rtl/multi_byte_add_seq_pkg.sv
// Shared constants for the byte-serial multi-precision add/subtract sequencer.
// Holds the FSM state encoding, the operand-width default and its legal range.
package multi_byte_add_seq_pkg;

    localparam int NBYTES_DEFAULT = 4;
    localparam int NBYTES_MIN     = 1;
    localparam int NBYTES_MAX     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The byte index is at least one bit wide, even when only one byte exists.
    function automatic int idxWidth(input int nBytes);
        return (nBytes > 1) ? $clog2(nBytes) : 1;
    endfunction

endpackage

// File: rtl/multi_byte_add_seq_if.sv
// Start and result handshakes of the multi-byte add/subtract sequencer.
// master = requester/consumer side, slave = the sequencer.
interface multi_byte_add_seq_if
    import multi_byte_add_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) ();

    logic                  startValid;
    logic                  startReady;
    logic [8*NBYTES-1:0]   opA;
    logic [8*NBYTES-1:0]   opB;
    logic                  sub;
    logic                  resValid;
    logic                  resReady;
    logic [8*NBYTES-1:0]   result;
    logic                  cOut;
    logic                  overflow;
    logic                  zero;

    modport master (
        output startValid, opA, opB, sub, resReady,
        input  startReady, resValid, result, cOut, overflow, zero
    );

    modport slave (
        input  startValid, opA, opB, sub, resReady,
        output startReady, resValid, result, cOut, overflow, zero
    );

endinterface

// File: rtl/multi_byte_add_seq_byte_add_cin.sv
// 8-bit ripple adder with carry-in; also exposes the carry into bit 7 so the
// caller can form signed overflow on the most significant byte.
module byte_add_cin (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cOut,
    output logic       c7
);

    logic [7:0] lowSum;
    logic [1:0] highSum;

    always_comb begin
        lowSum  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
        c7      = lowSum[7];
        highSum = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, c7};
        sum     = {highSum[0], lowSum[6:0]};
        cOut    = highSum[1];
    end

endmodule

// File: rtl/multi_byte_add_seq.sv
// Byte-serial multi-precision add/subtract: one 8-bit add-with-carry per cycle,
// LSB byte first, presenting the wide result and flags via a result handshake.
module multi_byte_add_seq
    import multi_byte_add_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multi_byte_add_seq_if.slave  bus
);

    localparam int IW = idxWidth(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t state, stateNext;

    logic [NBYTES-1:0][7:0] regA;
    logic [NBYTES-1:0][7:0] regB;
    logic [NBYTES-1:0][7:0] resultReg;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic                   ovf;

    logic                   accept;
    logic                   lastByte;
    logic [7:0]             sumByte;
    logic                   carryByte;
    logic                   c7Byte;

    byte_add_cin u_adder (
        .a    (regA[idx]),
        .b    (regB[idx]),
        .cin  (carry),
        .sum  (sumByte),
        .cOut (carryByte),
        .c7   (c7Byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext      = state;
        bus.startReady = 1'b0;
        bus.resValid   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.startReady = 1'b1;
                if (bus.startValid) stateNext = ST_RUN;
            end
            ST_RUN: begin
                if (lastByte) stateNext = ST_DONE;
            end
            ST_DONE: begin
                bus.resValid = 1'b1;
                if (bus.resReady) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign accept   = bus.startValid && (state == ST_IDLE);
    assign lastByte = (idx == LAST_IDX);

    // Operand registers are pure data: loaded on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            regA <= bus.opA;
            regB <= bus.sub ? ~bus.opB : bus.opB;
        end
    end

    // Subtract is A + ~B + 1, so the carry seed is the sub flag itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            resultReg <= '0;
        end else if (accept) begin
            idx   <= '0;
            carry <= bus.sub;
        end else if (state == ST_RUN) begin
            resultReg[idx] <= sumByte;
            carry          <= carryByte;
            if (lastByte) ovf <= c7Byte ^ carryByte;
            else          idx <= idx + 1'b1;
        end
    end

    assign bus.result   = resultReg;
    assign bus.cOut     = carry;
    assign bus.overflow = ovf;
    assign bus.zero     = (resultReg == '0);

endmodule
